// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM states and width default for the HI/LO multiply unit
package mdu_pkg;
  localparam int XLEN_DEF = 32;
  typedef enum logic [2:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_MADD  = 3'd3,
    MDU_MSUB  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } op_e;
  typedef enum logic [1:0] {IDLE, RUN, WB} state_e;
  function automatic logic is_mul(op_e o);
    return o == MDU_MULT || o == MDU_MULTU || o == MDU_MADD || o == MDU_MSUB;
  endfunction
endpackage

// File: rtl/hilo_mdu_if.sv
// hilo_mdu_if: issue/result bundle between EX stage (master) and the MDU (slave)
// start/op/a/b issue an operation; busy/done/hi/lo report progress and the HI/LO pair
interface hilo_mdu_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_mul_core.sv
// mdu_mul_core: magnitude latch, shift-add accumulator, step counter and sign fix-up
// Ports: clk/rst, load (latch operands), step (one RUN cycle), signed_op, a/b operands,
//        last (this step is the final one), product (signed-corrected 2*XLEN result).
// Optional MDU_EARLY_OUT_EN: last also asserts once no multiplier bits remain.
module mdu_mul_core
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              signed_op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              last,
  output logic [2*XLEN-1:0] product
);
  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  logic [2*XLEN-1:0] mcand, acc, addend;
  logic [XLEN-1:0]   mplier, a_mag, b_mag;
  logic [CW-1:0]     cnt;
  logic              sign;
  // negating the most negative value yields itself, which is the correct unsigned magnitude
  assign a_mag = (signed_op && a[XLEN-1]) ? -a : a;
  assign b_mag = (signed_op && b[XLEN-1]) ? -b : b;
  always_comb begin
    addend = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++)
      addend = addend + ({2*XLEN{mplier[i]}} & (mcand << i));
  end
`ifdef MDU_EARLY_OUT_EN
  assign last = (cnt == CW'(N - 1)) || ((mplier >> BITS_PER_CYCLE) == '0);
`else
  assign last = cnt == CW'(N - 1);
`endif
  assign product = sign ? -acc : acc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      sign   <= 1'b0;
    end else if (load) begin
      mcand  <= {{XLEN{1'b0}}, a_mag};
      mplier <= b_mag;
      acc    <= '0;
      cnt    <= '0;
      sign   <= signed_op & (a[XLEN-1] ^ b[XLEN-1]);
    end else if (step) begin
      acc    <= acc + addend;
      mcand  <= mcand << BITS_PER_CYCLE;
      mplier <= mplier >> BITS_PER_CYCLE;
      cnt    <= cnt + 1'b1;
    end
endmodule

// File: rtl/hilo_mdu.sv
// hilo_mdu: iterative multiply unit owning the architectural HI/LO pair
// Ports: Clk, Reset (async active-high), bus (slave: start/op/a/b in, busy/done/hi/lo out).
// Optional MDU_EARLY_OUT_EN: RUN ends as soon as the remaining multiplier bits are zero.
module hilo_mdu
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int BITS_PER_CYCLE = 2
) (
  input logic        Clk,
  input logic        Reset,
  hilo_mdu_if.slave  bus
);
  state_e            state;
  op_e               op_q, op_in;
  logic [XLEN-1:0]   hi, lo;
  logic [2*XLEN-1:0] p, hilo_next;
  logic              done, last, start_mul;
  assign op_in     = op_e'(bus.op);
  assign start_mul = state == IDLE && bus.start && is_mul(op_in);
  mdu_mul_core #(.XLEN(XLEN), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_core (
    .clk       (Clk),
    .rst       (Reset),
    .load      (start_mul),
    .step      (state == RUN),
    .signed_op (op_in != MDU_MULTU),
    .a         (bus.a),
    .b         (bus.b),
    .last      (last),
    .product   (p)
  );
  assign hilo_next = op_q == MDU_MADD ? {hi, lo} + p :
                     op_q == MDU_MSUB ? {hi, lo} - p : p;
  assign bus.busy = state != IDLE;
  assign bus.done = done;
  assign bus.hi   = hi;
  assign bus.lo   = lo;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      op_q  <= MDU_NOP;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          if (op_in == MDU_MTHI) hi <= bus.a;
          if (op_in == MDU_MTLO) lo <= bus.a;
          if (is_mul(op_in)) begin
            op_q  <= op_in;
            state <= RUN;
          end
        end
        RUN: if (last) state <= WB;
        WB: begin
          {hi, lo} <= hilo_next;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: directed plus random checks of hilo_mdu against an arithmetic HI/LO model
module tb_hilo_mdu;
  import mdu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  hilo_mdu_if #(.XLEN(32)) bus();
  hilo_mdu dut (.Clk(clk), .Reset(rst), .bus(bus));
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int lat = 0;
  logic [63:0] m = '0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] h);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = (o == 3'(MDU_MULTU)) ? {32'b0, a} * {32'b0, b} : 64'(sa * sb);
    return o == 3'(MDU_MADD) ? h + p : o == 3'(MDU_MSUB) ? h - p : p;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = o;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    t0 = cyc;
    bus.start = 1'b0;
    bus.op = 3'(MDU_NOP);
    if (o == 3'(MDU_MTHI)) m[63:32] = a;
    else if (o == 3'(MDU_MTLO)) m[31:0] = a;
    else if (o >= 3'(MDU_MULT) && o <= 3'(MDU_MSUB)) m = model(o, a, b, m);
  endtask

  task automatic wait_done(input string tag);
    bit busy_ok = 1'b1;
    while (!bus.done && cyc - t0 < 40) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      bus.a = $urandom;
      bus.b = $urandom;
      @(posedge clk);
      #1;
    end
    lat = cyc - t0;
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
    chk({tag, "_busy_off"}, 64'(bus.busy), 64'd0);
    chk({tag, "_hilo"}, {bus.hi, bus.lo}, m);
`ifdef MDU_EARLY_OUT_EN
    chk({tag, "_lat_range"}, 64'(lat >= 2 && lat <= 17), 64'd1);
`else
    chk({tag, "_lat"}, 64'(lat), 64'd17);
`endif
  endtask

  initial begin
    bit seen;
    logic [31:0] corner [5] = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    bus.start = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    #1;
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(3'(MDU_MULT), 32'hFFFF_FFFD, 32'd5);
    wait_done("mult_neg");
    chk("mult_neg_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    issue(3'(MDU_MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max");
    chk("multu_max_const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    issue(3'(MDU_MULT), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mult_m1");
    chk("mult_m1_const", {bus.hi, bus.lo}, 64'h1);
    issue(3'(MDU_MULT), 32'h8000_0000, 32'h8000_0000);
    wait_done("mult_minneg");
    chk("mult_minneg_const", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
    issue(3'(MDU_MTLO), 32'd10, 32'd0);
    chk("mtlo_done", 64'(bus.done), 64'd0);
    chk("mtlo_busy", 64'(bus.busy), 64'd0);
    issue(3'(MDU_MTHI), 32'd0, 32'd0);
    chk("mthi_hilo", {bus.hi, bus.lo}, 64'd10);
    issue(3'(MDU_NOP), 32'hDEAD, 32'hBEEF);
    issue(3'(MDU_RSVD), 32'hDEAD, 32'hBEEF);
    chk("nop_hilo", {bus.hi, bus.lo}, 64'd10);
    chk("nop_busy", 64'(bus.busy), 64'd0);
    issue(3'(MDU_MADD), 32'd2, 32'd3);
    wait_done("madd");
    chk("madd_const", {bus.hi, bus.lo}, 64'd16);
    issue(3'(MDU_MSUB), 32'd4, 32'd5);
    wait_done("msub");
    chk("msub_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFC);
    issue(3'(MDU_MULT), 32'd7, 32'd9);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 3'(MDU_MTHI);
    bus.a = 32'h1234;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op = 3'(MDU_NOP);
    wait_done("busy_ignore");
    chk("busy_ignore_const", {bus.hi, bus.lo}, 64'd63);
    issue(3'(MDU_MULT), 32'd11, 32'hFFFF_FFFE);
    wait_done("back2back");
    issue(3'(MDU_MULT), 32'h1357_9BDF, 32'h2468_ACE0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("rst_mid_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m = '0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.done) seen = 1'b1;
    end
    chk("rst_no_done", 64'(seen), 64'd0);
    chk("rst_hilo_hold", {bus.hi, bus.lo}, 64'd0);
    issue(3'(MDU_MULT), 32'd2, 32'd2);
    wait_done("after_rst");
    chk("after_rst_const", {bus.hi, bus.lo}, 64'd4);
`ifdef MDU_EARLY_OUT_EN
    issue(3'(MDU_MULTU), 32'hFFFF, 32'd1);
    wait_done("early_b1");
    chk("early_b1_lat", 64'(lat <= 2), 64'd1);
    chk("early_b1_const", {bus.hi, bus.lo}, 64'hFFFF);
    issue(3'(MDU_MULTU), 32'hFFFF, 32'd0);
    wait_done("early_b0");
    chk("early_b0_const", {bus.hi, bus.lo}, 64'd0);
`endif
    for (int i = 0; i < 40; i++) begin
      logic [2:0] o;
      logic [31:0] a, b;
      o = 3'($urandom_range(1, 6));
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      issue(o, a, b);
      if (o <= 3'(MDU_MSUB)) wait_done("rand_mul");
      else chk("rand_move", {bus.hi, bus.lo}, m);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
